// File: rtl/seven_seg_scan_mux_if.sv
// seven_seg_scan_mux_if: load-side and display-side signals of the scan controller.
// Latency: none; wiring only.
// Backpressure: none; the load side is fire-and-forget.
interface seven_seg_scan_mux_if #(
    parameter int DIGITS = 4
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  enable;
    logic [4*DIGITS-1:0]   value_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  load;
    logic                  load_ack;
    logic                  pending;
    logic [3:0]            nibble_out;
    logic                  dp_out;
    logic                  blank_out;
    logic [DIGITS-1:0]     digit_en_n;
    logic [IW-1:0]         digit_idx;

    modport master (
        output enable, value_in, dp_in, load,
        input  load_ack, pending, nibble_out, dp_out, blank_out, digit_en_n, digit_idx
    );

    modport slave (
        input  enable, value_in, dp_in, load,
        output load_ack, pending, nibble_out, dp_out, blank_out, digit_en_n, digit_idx
    );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: round-robin digit scan with frame-aligned commit of staged data.
// Latency: all outputs registered; staged data commits at the next frame wrap, or next edge when off.
// Backpressure: none, a repeated load overwrites staging. SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_seg_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input logic                 clk,
    input logic                 rst,
    seven_seg_scan_mux_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {OFF, SCAN} state_t;

    state_t                   state, nxt_state;
    logic [CW-1:0]            cnt, nxt_cnt;
    logic [IW-1:0]            idx, nxt_idx;
    logic [DIGITS-1:0][3:0]   disp_reg, nxt_disp, stage_val;
    logic [DIGITS-1:0]        disp_dp, nxt_dp, stage_dp;
    logic [DIGITS-1:0]        blank_mask;
    logic [DIGITS-1:0]        en_n;
    logic                     pending, commit, show;

    always_comb begin
        nxt_state = bus.enable ? SCAN : OFF;
        nxt_cnt   = '0;
        nxt_idx   = '0;
        commit    = 1'b0;
        if (state == OFF) begin
            commit = pending;
        end else if (bus.enable) begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                if (idx == IW'(DIGITS - 1)) begin
                    commit = pending;
                end else begin
                    nxt_idx = idx + IW'(1);
                end
            end else begin
                nxt_cnt = cnt + CW'(1);
                nxt_idx = idx;
            end
        end
        nxt_disp = commit ? stage_val : disp_reg;
        nxt_dp   = commit ? stage_dp  : disp_dp;
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Mask follows the display word, so it can only change when a commit lands.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above    = zero_above & (nxt_disp[i] == 4'h0);
            blank_mask[i] = zero_above;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        show = (nxt_state == SCAN) && (nxt_cnt >= CW'(GUARD)) && !blank_mask[nxt_idx];
        en_n = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (show && (nxt_idx == IW'(i))) en_n[i] = 1'b0;
        end
    end

    // Outputs are registered from next-state values so they line up with cnt/idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= OFF;
            cnt            <= '0;
            idx            <= '0;
            disp_reg       <= '0;
            disp_dp        <= '0;
            stage_val      <= '0;
            stage_dp       <= '0;
            pending        <= 1'b0;
            bus.load_ack   <= 1'b0;
            bus.pending    <= 1'b0;
            bus.nibble_out <= 4'h0;
            bus.dp_out     <= 1'b0;
            bus.blank_out  <= 1'b1;
            bus.digit_en_n <= '1;
            bus.digit_idx  <= '0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            idx      <= nxt_idx;
            disp_reg <= nxt_disp;
            disp_dp  <= nxt_dp;
            if (bus.load) begin
                stage_val <= bus.value_in;
                stage_dp  <= bus.dp_in;
                pending   <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            bus.load_ack   <= commit;
            bus.pending    <= bus.load | (pending & ~commit);
            bus.nibble_out <= nxt_disp[nxt_idx];
            bus.dp_out     <= nxt_dp[nxt_idx] & ~blank_mask[nxt_idx];
            bus.blank_out  <= ~show;
            bus.digit_en_n <= en_n;
            bus.digit_idx  <= nxt_idx;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb_seven_seg_scan_mux: directed scan, commit, enable-drop and blanking checks.
// Latency: samples on the falling edge, one half-cycle after each active edge.
// Backpressure: not applicable.
module tb_seven_seg_scan_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_mux_if #(.DIGITS(4)) bus ();

    seven_seg_scan_mux #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] MASK_0042 = 4'b1100;
    localparam logic [3:0] MASK_0000 = 4'b1110;
`else
    localparam logic [3:0] MASK_0042 = 4'b0000;
    localparam logic [3:0] MASK_0000 = 4'b0000;
`endif

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 40; i++) begin
            if (bus.load_ack === 1'b1) break;
            step();
        end
        chk("ack_seen", {31'd0, bus.load_ack}, 32'd1);
    endtask

    // Checks one full frame starting at the guard cycle of digit 0; optional loads at cycles ca/cb.
    task automatic observe_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mask,
                                 input int ca, input logic [19:0] la,
                                 input int cb, input logic [19:0] lb);
        int low [4];
        low = '{default: 0};
        for (int c = 0; c < 16; c++) begin
            int d;
            int s;
            logic [3:0] een;
            logic [15:0] vv;
            d   = c / 4;
            s   = c % 4;
            vv  = v >> (4 * d);
            een = 4'b1111;
            if (s >= 1 && !mask[d]) een[d] = 1'b0;
            chk($sformatf("idx_c%0d", c), {30'd0, bus.digit_idx}, d);
            chk($sformatf("en_c%0d", c), {28'd0, bus.digit_en_n}, {28'd0, een});
            chk($sformatf("nib_c%0d", c), {28'd0, bus.nibble_out}, {28'd0, vv[3:0]});
            chk($sformatf("blank_c%0d", c), {31'd0, bus.blank_out}, {31'd0, (s == 0) || mask[d]});
            chk($sformatf("dp_c%0d", c), {31'd0, bus.dp_out}, {31'd0, dp[d] & ~mask[d]});
            if (c > 0) chk($sformatf("noack_c%0d", c), {31'd0, bus.load_ack}, 32'd0);
            if (bus.digit_en_n[d] === 1'b0) low[d]++;
            if (c == ca) begin
                bus.load = 1'b1;
                {bus.dp_in, bus.value_in} = la;
            end else if (c == cb) begin
                bus.load = 1'b1;
                {bus.dp_in, bus.value_in} = lb;
            end
            step();
            bus.load = 1'b0;
        end
        for (int d = 0; d < 4; d++)
            chk($sformatf("lowcnt_d%0d", d), low[d], mask[d] ? 0 : 3);
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = '0;
        bus.dp_in    = '0;

        // Reset
        step();
        step();
        chk("rst_en", {28'd0, bus.digit_en_n}, 32'hF);
        chk("rst_blank", {31'd0, bus.blank_out}, 32'd1);
        chk("rst_ack", {31'd0, bus.load_ack}, 32'd0);
        chk("rst_pend", {31'd0, bus.pending}, 32'd0);
        chk("rst_nib", {28'd0, bus.nibble_out}, 32'd0);
        chk("rst_idx", {30'd0, bus.digit_idx}, 32'd0);
        rst = 1'b0;
        bus.enable = 1'b1;
        step();
        chk("en_guard", {28'd0, bus.digit_en_n}, 32'hF);
        chk("en_guard_blank", {31'd0, bus.blank_out}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("d0_en_%0d", i), {28'd0, bus.digit_en_n}, 32'hE);
            chk($sformatf("d0_nib_%0d", i), {28'd0, bus.nibble_out}, 32'd0);
            chk($sformatf("d0_ack_%0d", i), {31'd0, bus.load_ack}, 32'd0);
        end

        // Scan order
        bus.load = 1'b1;
        bus.value_in = 16'h1A2F;
        bus.dp_in = 4'b0101;
        step();
        bus.load = 1'b0;
        chk("pend_1a2f", {31'd0, bus.pending}, 32'd1);
        chk("noack_1a2f", {31'd0, bus.load_ack}, 32'd0);
        wait_ack();
        chk("pend_clr_1a2f", {31'd0, bus.pending}, 32'd0);
        observe_frame(16'h1A2F, 4'b0101, 4'b0000, 0, {4'b0000, 16'hABCD}, -1, 20'h0);

        // Frame commit with mid-frame load
        chk("ack_abcd", {31'd0, bus.load_ack}, 32'd1);
        observe_frame(16'hABCD, 4'b0000, 4'b0000, 6, {4'b0011, 16'h1234}, -1, 20'h0);
        chk("ack_1234", {31'd0, bus.load_ack}, 32'd1);
        chk("pend_1234", {31'd0, bus.pending}, 32'd0);

        // Load on the commit edge
        observe_frame(16'h1234, 4'b0011, 4'b0000, 0, {4'b1001, 16'h6789}, 15, {4'b0110, 16'h5555});
        chk("ack_6789", {31'd0, bus.load_ack}, 32'd1);
        chk("pend_5555_held", {31'd0, bus.pending}, 32'd1);
        observe_frame(16'h6789, 4'b1001, 4'b0000, -1, 20'h0, -1, 20'h0);
        chk("ack_5555", {31'd0, bus.load_ack}, 32'd1);
        chk("pend_5555_clr", {31'd0, bus.pending}, 32'd0);

        // Enable drop while digit 2 is active
        for (int i = 0; i < 10; i++) step();
        chk("d2_idx", {30'd0, bus.digit_idx}, 32'd2);
        chk("d2_en", {28'd0, bus.digit_en_n}, 32'hB);
        chk("d2_dp", {31'd0, bus.dp_out}, 32'd1);
        bus.enable = 1'b0;
        step();
        chk("off_en", {28'd0, bus.digit_en_n}, 32'hF);
        chk("off_idx", {30'd0, bus.digit_idx}, 32'd0);
        chk("off_blank", {31'd0, bus.blank_out}, 32'd1);
        bus.load = 1'b1;
        bus.value_in = 16'h0042;
        bus.dp_in = 4'b1000;
        step();
        bus.load = 1'b0;
        chk("off_pend", {31'd0, bus.pending}, 32'd1);
        chk("off_noack", {31'd0, bus.load_ack}, 32'd0);
        step();
        chk("off_ack", {31'd0, bus.load_ack}, 32'd1);
        chk("off_pend_clr", {31'd0, bus.pending}, 32'd0);
        chk("off_nib", {28'd0, bus.nibble_out}, 32'd2);
        chk("off_en2", {28'd0, bus.digit_en_n}, 32'hF);
        bus.enable = 1'b1;
        step();

        // Blanking (or full display without the macro)
        observe_frame(16'h0042, 4'b1000, MASK_0042, 0, {4'b0001, 16'h0000}, -1, 20'h0);
        chk("ack_0000", {31'd0, bus.load_ack}, 32'd1);
        observe_frame(16'h0000, 4'b0001, MASK_0000, -1, 20'h0, -1, 20'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Time-multiplexed scan controller for a DIGITS-digit common-anode 7-segment display.
- Holds a committed display word and selects one digit at a time, round-robin.
- Drives the selected 4-bit nibble to the downstream hex-to-seven-segment decoder, and drives the active-low digit enables directly.
- New values commit only at frame boundaries, so a digit never shows a mix of old and new data.

Parameters:
- DIGITS, 4: number of digits scanned.
- REFRESH_DIV, 50000: clock cycles per digit slot (minimum 2).
- GUARD, 2: cycles at the start of each slot with all digits off (anti-ghosting); must be less than REFRESH_DIV.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- enable, input, 1: 1 = scan; 0 = all digits off.
- value_in, input, 4*DIGITS: hex value to display; nibble 0 (bits 3:0) is the rightmost digit.
- dp_in, input, DIGITS: decimal-point request per digit.
- load, input, 1: capture value_in/dp_in into staging this cycle.
- load_ack, output, 1: one-cycle pulse when staging commits to the display register.
- pending, output, 1: staged data is not yet committed.
- nibble_out, output, 4: nibble of the current digit; goes to the decoder input.
- dp_out, output, 1: decimal point of the current digit, active-high.
- blank_out, output, 1: 1 = decoder output must be forced off.
- digit_en_n, output, DIGITS: digit enables, active-low, at most one bit low.
- digit_idx, output, clog2(DIGITS): current digit index.

Behaviour:
- Reset: cnt=0; digit_idx=0; disp_reg=0; disp_dp=0; staging=0; pending=0; load_ack=0; digit_en_n all ones; nibble_out=0; dp_out=0; blank_out=1.
- All outputs are registered. There is no combinational path from any input to any output.
- States: OFF (enable=0) and SCAN (enable=1).
- OFF:
  - cnt=0, digit_idx=0.
  - digit_en_n all ones, blank_out=1.
- OFF -> SCAN on enable=1:
  - First slot is digit 0 and starts with the guard period.
- SCAN -> OFF on enable=0:
  - Next edge: digit_en_n all ones, cnt=0, digit_idx=0.
  - Applies at any point in a slot or frame.
- Divider in SCAN:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt=REFRESH_DIV-1: cnt wraps to 0 and digit_idx increments, wrapping DIGITS-1 -> 0.
- Slot outputs:
  - nibble_out = disp_reg[4*idx +: 4].
  - dp_out = disp_dp[idx].
  - While cnt < GUARD: digit_en_n all ones, blank_out=1.
  - Otherwise: bit idx of digit_en_n is low and blank_out=0, unless that digit is blanked (see Optional Feature).
- Load:
  - load=1: staging <= {value_in, dp_in}; pending <= 1.
  - A repeated load while pending overwrites staging; the latest value wins. There is no backpressure.
- Commit, in SCAN, on the wrap edge (digit_idx DIGITS-1 -> 0) with pending=1:
  - disp_reg/disp_dp <= staging; pending <= 0; load_ack=1 for one cycle.
- Commit in OFF:
  - Any pending data commits on the next edge, with load_ack pulsing.
- load on the same edge as a commit:
  - The commit uses the staging value from before the edge.
  - The new load overwrites staging and pending stays 1; it commits at the next boundary.
- rst overrides everything, including mid-slot and mid-commit.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most-significant nonzero nibble of disp_reg are blanked: digit_en_n bit stays high and blank_out=1 for that slot.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - dp_in on a blanked digit is ignored.
  - The blank mask is computed from disp_reg only and changes only at commit.
- Undefined: all digits display, including leading zeros.

Test Plan (DIGITS=4, REFRESH_DIV=4, GUARD=1):
- Reset: rst=1 for 2 cycles, then enable=1 -> digit_en_n=4'b1111 on cnt=0, then 4'b1110 with nibble_out=0 on cnt 1..3; load_ack never pulses.
- Scan order: load 16'h1A2F, wait for load_ack, then observe one frame -> nibble_out sequence F,2,A,1; digit_en_n 1110, 1101, 1011, 0111; each digit low for exactly 3 of 4 cycles.
- Frame commit: load 16'h1234 mid-frame while 16'hABCD is displayed -> remaining digits still show ABCD; load_ack pulses on the wrap edge; next frame shows 4,3,2,1.
- Load on commit edge: load 16'h5555 exactly on the wrap edge -> the prior staged value displays; pending stays 1; 5555 commits at the following wrap.
- Enable drop: enable=0 while digit 2 is active -> next cycle digit_en_n=1111, digit_idx=0; load 16'h0042 while OFF -> load_ack next cycle; re-enable starts at digit 0.
- Blanking: load 16'h0042 with the macro defined -> digits 3 and 2 stay 1 with blank_out=1, digits 1 and 0 show 4 and 2; 16'h0000 shows only digit 0. With the macro undefined -> all four digits show.
